// File: rtl/checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : checker_pkg
//  Description : Shared types and constants for the DM end-of-test checker.
//                Holds the checker FSM state type, the default result-window
//                and sentinel constants, and small width helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } chk_state_t;

    localparam logic [15:0] C_TEST_START   = 16'h2000;
    localparam logic [15:0] C_SIM_END_ADDR = 16'h3fff;
    localparam logic [31:0] C_SIM_END_CODE = 32'hffff_ffff;

    // Index width for 0..n-1; never collapses to zero bits when n == 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/checker_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : checker_scan_ctrl
//  Description : Result-window scan engine. Issues TEST_LEN read requests
//                (DM address and golden ROM index) one per cycle, compares
//                the returned words one cycle later, counts mismatches with
//                saturation and latches the first failing DM address.
//  Ports       : clk, rst          - clock, async active-high reset
//                i_launch          - start a scan (index 0 issues next cycle)
//                i_clear           - clear error count and first-error latch
//                i_rd_data         - DM read data (1-cycle latency)
//                i_gold_data       - golden ROM data (1-cycle latency)
//                o_rd_en/o_rd_addr - DM read request
//                o_gold_addr       - golden ROM index
//                o_err_cnt         - mismatch count
//                o_first_err_*     - first mismatch flag and address
//                o_last_cmp        - final compare of the window this cycle
//                o_final_zero      - error count after this cycle's compare is 0
//  Revision    : 1.0 - initial release
// ============================================================================
module checker_scan_ctrl
    import checker_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] TEST_START = ADDR_W'(C_TEST_START),
    parameter int                TEST_LEN   = 64,
    parameter int                IDX_W      = idx_w(TEST_LEN),
    parameter int                CNT_W      = cnt_w(TEST_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_launch,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic [DATA_W-1:0] i_gold_data,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [IDX_W-1:0]  o_gold_addr,
    output logic [CNT_W-1:0]  o_err_cnt,
    output logic              o_first_err_valid,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic              o_last_cmp,
    output logic              o_final_zero
);

    // Issue stage
    logic              r_issue;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_rd_addr;

    // Compare stage
    logic              r_cmp_vld;
    logic              r_cmp_last;
    logic [ADDR_W-1:0] r_cmp_addr;

    // Results
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_first_vld;
    logic [ADDR_W-1:0] r_first_addr;

    logic              w_issue_last;
    logic              w_mismatch;
    logic [CNT_W-1:0]  w_err_next;

    assign w_issue_last = r_issue && (r_idx == IDX_W'(TEST_LEN - 1));
    assign w_mismatch   = r_cmp_vld && (i_rd_data != i_gold_data);
    assign w_err_next   = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + CNT_W'(1)
                                                            : r_err_cnt;

    // The DM address is kept as its own register (rather than derived from
    // the index) so it reads 0 out of reset and wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue   <= 1'b0;
            r_idx     <= '0;
            r_rd_addr <= '0;
        end else if (i_launch) begin
            r_issue   <= 1'b1;
            r_idx     <= '0;
            r_rd_addr <= TEST_START;
        end else if (r_issue) begin
            if (w_issue_last) begin
                r_issue <= 1'b0;
            end else begin
                r_idx     <= r_idx + IDX_W'(1);
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
        end
    end

    // Read data returns one cycle after the request, so the request's
    // address and last-flag ride along one stage to meet it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp_vld  <= 1'b0;
            r_cmp_last <= 1'b0;
            r_cmp_addr <= '0;
        end else begin
            r_cmp_vld  <= r_issue;
            r_cmp_last <= w_issue_last;
            r_cmp_addr <= r_rd_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt    <= '0;
            r_first_vld  <= 1'b0;
            r_first_addr <= '0;
        end else if (i_clear) begin
            r_err_cnt    <= '0;
            r_first_vld  <= 1'b0;
            r_first_addr <= '0;
        end else if (r_cmp_vld) begin
            r_err_cnt <= w_err_next;
            if (w_mismatch && !r_first_vld) begin
                r_first_vld  <= 1'b1;
                r_first_addr <= r_cmp_addr;
            end
        end
    end

    assign o_rd_en           = r_issue;
    assign o_rd_addr         = r_rd_addr;
    assign o_gold_addr       = r_idx;
    assign o_err_cnt         = r_err_cnt;
    assign o_first_err_valid = r_first_vld;
    assign o_first_err_addr  = r_first_addr;
    assign o_last_cmp        = r_cmp_vld && r_cmp_last;
    assign o_final_zero      = (w_err_next == '0);

endmodule
`default_nettype wire

// File: rtl/dm_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : dm_result_checker
//  Description : End-of-test checker for the single-cycle CPU. Snoops the
//                data-memory write port for the sim-end sentinel, then scans
//                the DM result window against a golden ROM and reports
//                pass/fail, error count and the first failing address.
//  Config      : CHECKER_TIMEOUT_EN - when defined, a RUN-cycle counter forces
//                the scan after MAX_CYCLES cycles without a sentinel and
//                flags `timeout`; when undefined `timeout` is tied to 0.
//  Ports       : clk, rst                    - clock, async active-high reset
//                start                       - arm pulse (IDLE/DONE only)
//                dm_we/dm_waddr/dm_wdata     - snooped DM write port
//                dm_rd_en/dm_rd_addr         - scan read request
//                dm_rd_data                  - DM read data (1-cycle latency)
//                gold_rd_addr/gold_rd_data   - golden ROM port (same latency)
//                busy, done, pass, timeout   - status
//                err_cnt, first_err_valid,
//                first_err_addr              - diagnostics
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_result_checker
    import checker_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] TEST_START   = ADDR_W'(C_TEST_START),
    parameter int                TEST_LEN     = 64,
    parameter logic [ADDR_W-1:0] SIM_END_ADDR = ADDR_W'(C_SIM_END_ADDR),
    parameter logic [DATA_W-1:0] SIM_END_CODE = DATA_W'(C_SIM_END_CODE),
    parameter int                MAX_CYCLES   = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DATA_W/8-1:0]           dm_we,
    input  logic [ADDR_W-1:0]             dm_waddr,
    input  logic [DATA_W-1:0]             dm_wdata,
    output logic                          dm_rd_en,
    output logic [ADDR_W-1:0]             dm_rd_addr,
    input  logic [DATA_W-1:0]             dm_rd_data,
    output logic [idx_w(TEST_LEN)-1:0]    gold_rd_addr,
    input  logic [DATA_W-1:0]             gold_rd_data,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [cnt_w(TEST_LEN)-1:0]    err_cnt,
    output logic                          first_err_valid,
    output logic [ADDR_W-1:0]             first_err_addr
);

    localparam int IDX_W = idx_w(TEST_LEN);
    localparam int CNT_W = cnt_w(TEST_LEN);

    chk_state_t r_state;
    chk_state_t w_state_next;

    logic r_busy;
    logic r_done;
    logic r_pass;

    logic w_sentinel;
    logic w_limit;
    logic w_launch;
    logic w_clear;
    logic w_timeout_hit;
    logic w_timeout_flag;
    logic w_last_cmp;
    logic w_final_zero;

    // Only a full-word write counts; partial strobes to the sentinel
    // address are ordinary stores.
    assign w_sentinel = (&dm_we) && (dm_waddr == SIM_END_ADDR) &&
                        (dm_wdata == SIM_END_CODE);

    always_comb begin
        w_state_next  = r_state;
        w_launch      = 1'b0;
        w_clear       = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_clear      = 1'b1;
                end
            end
            ST_RUN: begin
                // Sentinel is tested first so it wins a tie with the limit.
                if (w_sentinel) begin
                    w_state_next = ST_SCAN;
                    w_launch     = 1'b1;
                end else if (w_limit) begin
                    w_state_next  = ST_SCAN;
                    w_launch      = 1'b1;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_SCAN: begin
                if (w_last_cmp) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with
    // the state register and can never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN) || (w_state_next == ST_SCAN);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    // pass uses the error count including the compare finishing this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass <= 1'b0;
        end else if (w_clear) begin
            r_pass <= 1'b0;
        end else if ((r_state == ST_SCAN) && w_last_cmp) begin
            r_pass <= w_final_zero && !w_timeout_flag;
        end
    end

`ifdef CHECKER_TIMEOUT_EN
    localparam int RC_W = idx_w(MAX_CYCLES);

    logic [RC_W-1:0] r_run_cnt;
    logic            r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_clear) begin
                r_run_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_run_cnt <= r_run_cnt + RC_W'(1);
            end

            if (w_clear) begin
                r_timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_limit        = (r_run_cnt == RC_W'(MAX_CYCLES - 1));
    assign w_timeout_flag = r_timeout;
`else
    logic w_unused_cfg;

    assign w_unused_cfg   = (MAX_CYCLES != 0) ^ w_timeout_hit;
    assign w_limit        = 1'b0;
    assign w_timeout_flag = 1'b0;
`endif

    checker_scan_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TEST_START (TEST_START),
        .TEST_LEN   (TEST_LEN),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W)
    ) u_scan (
        .clk               (clk),
        .rst               (rst),
        .i_launch          (w_launch),
        .i_clear           (w_clear),
        .i_rd_data         (dm_rd_data),
        .i_gold_data       (gold_rd_data),
        .o_rd_en           (dm_rd_en),
        .o_rd_addr         (dm_rd_addr),
        .o_gold_addr       (gold_rd_addr),
        .o_err_cnt         (err_cnt),
        .o_first_err_valid (first_err_valid),
        .o_first_err_addr  (first_err_addr),
        .o_last_cmp        (w_last_cmp),
        .o_final_zero      (w_final_zero)
    );

    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign timeout = w_timeout_flag;

endmodule
`default_nettype wire

// File: tb/tb_dm_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_result_checker
//  Description : Self-checking bench for dm_result_checker. Models the data
//                memory and golden ROM with one-cycle read latency, drives
//                snooped writes and the sentinel, and scores each finished
//                scan against a queue of expected results computed from the
//                bench's own memory images.
//  Config      : CHECKER_TIMEOUT_EN - enables the cycle-limit scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_result_checker;
    import checker_pkg::*;

    localparam int TLEN   = 64;
    localparam int MAXCYC = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  dm_we;
    logic [15:0] dm_waddr;
    logic [31:0] dm_wdata;
    logic        dm_rd_en;
    logic [15:0] dm_rd_addr;
    logic [31:0] dm_rd_data;
    logic [5:0]  gold_rd_addr;
    logic [31:0] gold_rd_data;
    logic        busy, done, pass, timeout;
    logic [6:0]  err_cnt;
    logic        first_err_valid;
    logic [15:0] first_err_addr;

    always #5 clk = ~clk;

    dm_result_checker #(
        .ADDR_W       (16),
        .DATA_W       (32),
        .TEST_START   (C_TEST_START),
        .TEST_LEN     (TLEN),
        .SIM_END_ADDR (C_SIM_END_ADDR),
        .SIM_END_CODE (C_SIM_END_CODE),
        .MAX_CYCLES   (MAXCYC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .dm_we           (dm_we),
        .dm_waddr        (dm_waddr),
        .dm_wdata        (dm_wdata),
        .dm_rd_en        (dm_rd_en),
        .dm_rd_addr      (dm_rd_addr),
        .dm_rd_data      (dm_rd_data),
        .gold_rd_addr    (gold_rd_addr),
        .gold_rd_data    (gold_rd_data),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout         (timeout),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr)
    );

    // Memory models: synchronous read, data valid the cycle after the request
    logic [31:0] mem  [0:65535];
    logic [31:0] gold [0:TLEN-1];

    always @(posedge clk) begin
        if (dm_rd_en) begin
            dm_rd_data   <= mem[dm_rd_addr];
            gold_rd_data <= gold[gold_rd_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        pass;
        int          err;
        logic        fv;
        logic [15:0] fa;
        logic        to;
        int          scan_edge;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Expected result from the bench's memory images at the moment of push
    task automatic push_expect(input int scan_edge, input logic to);
        exp_t        e;
        logic [15:0] a;
        e.err = 0;
        e.fv  = 1'b0;
        e.fa  = '0;
        for (int i = 0; i < TLEN; i++) begin
            a = C_TEST_START + 16'(i);
            if (mem[a] != gold[i]) begin
                e.err++;
                if (!e.fv) begin
                    e.fv = 1'b1;
                    e.fa = a;
                end
            end
        end
        e.to        = to;
        e.pass      = (e.err == 0) && !to;
        e.scan_edge = scan_edge;
        sb.push_back(e);
    endtask

    // All drivers are called at a negedge and return at a negedge
    task automatic snoop_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] we);
        dm_we    = we;
        dm_waddr = a;
        dm_wdata = d;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[a][8*b +: 8] = d[8*b +: 8];
        end
        @(negedge clk);
        dm_we = 4'h0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_sentinel();
        push_expect(cyc + 1, 1'b0);
        snoop_wr(C_SIM_END_ADDR, C_SIM_END_CODE, 4'hf);
    endtask

    task automatic fill_window(input logic [31:0] v);
        for (int i = 0; i < TLEN; i++) snoop_wr(C_TEST_START + 16'(i), v, 4'hf);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!(done && sb.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", {31'b0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   {31'b0, busy},            0);
        chk({tag, "_done"},   {31'b0, done},            0);
        chk({tag, "_pass"},   {31'b0, pass},            0);
        chk({tag, "_tmo"},    {31'b0, timeout},         0);
        chk({tag, "_errcnt"}, {25'b0, err_cnt},         0);
        chk({tag, "_fvld"},   {31'b0, first_err_valid}, 0);
        chk({tag, "_faddr"},  {16'b0, first_err_addr},  0);
        chk({tag, "_rden"},   {31'b0, dm_rd_en},        0);
        chk({tag, "_rdaddr"}, {16'b0, dm_rd_addr},      0);
        chk({tag, "_gaddr"},  {26'b0, gold_rd_addr},    0);
    endtask

    // Scoreboard monitor: scores every rising edge of done
    initial begin : mon
        logic prev_done;
        int   rd_cnt;
        exp_t e;
        prev_done = 1'b0;
        rd_cnt    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
                rd_cnt    = 0;
            end else begin
                if (dm_rd_en) rd_cnt++;
                if (busy && done) chk("busy_and_done", {31'b0, busy}, 0);
                if (done && !prev_done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", {31'b0, done}, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("pass",      {31'b0, pass},            {31'b0, e.pass});
                        chk("err_cnt",   {25'b0, err_cnt},         e.err);
                        chk("first_vld", {31'b0, first_err_valid}, {31'b0, e.fv});
                        if (e.fv) chk("first_addr", {16'b0, first_err_addr}, {16'b0, e.fa});
                        chk("timeout",   {31'b0, timeout},         {31'b0, e.to});
                        chk("latency",   cyc - e.scan_edge,        TLEN + 1);
                        chk("rd_cycles", rd_cnt,                   TLEN);
                    end
                    rd_cnt = 0;
                end
                prev_done = done;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1);
    end

    initial begin : stim
        int c;
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        dm_we    = 4'h0;
        dm_waddr = '0;
        dm_wdata = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        for (int i = 0; i < TLEN; i++)  gold[i] = 32'h1;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Clean pass
        pulse_start();
        chk("busy_after_start", {31'b0, busy}, 1);
        fill_window(32'h1);
        send_sentinel();
        wait_done(200);

        // Restart from DONE clears results; two mismatches; start in RUN ignored
        pulse_start();
        chk("restart_busy", {31'b0, busy}, 1);
        chk("restart_done", {31'b0, done}, 0);
        chk("restart_pass", {31'b0, pass}, 0);
        snoop_wr(16'h2005, 32'hdead, 4'hf);
        snoop_wr(16'h2010, 32'hbeef, 4'hf);
        pulse_start();
        chk("start_in_run_busy", {31'b0, busy}, 1);
        send_sentinel();
        wait_done(200);

        // Results cleared by the next start
        pulse_start();
        chk("clear_errcnt", {25'b0, err_cnt},         0);
        chk("clear_fvld",   {31'b0, first_err_valid}, 0);

        // Partial-strobe sentinel is ignored, full one triggers the scan
        snoop_wr(C_SIM_END_ADDR, C_SIM_END_CODE, 4'h3);
        repeat (5) @(negedge clk);
        chk("partial_busy", {31'b0, busy},     1);
        chk("partial_rden", {31'b0, dm_rd_en}, 0);
        send_sentinel();
        wait_done(200);

        // Reset in the middle of a scan
        snoop_wr(16'h2005, 32'h1, 4'hf);
        snoop_wr(16'h2010, 32'h1, 4'hf);
        pulse_start();
        send_sentinel();
        n = 0;
        while (!(dm_rd_en && gold_rd_addr == 6'd20) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idx20", {26'b0, gold_rd_addr}, 20);
        #1 rst = 1'b1;
        #1 chk_all_zero("midscan_rst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        send_sentinel();
        wait_done(200);

`ifdef CHECKER_TIMEOUT_EN
        // No sentinel: cycle limit forces the scan
        c = cyc;
        push_expect(c + MAXCYC + 1, 1'b1);
        pulse_start();
        wait_done(400);

        // Sentinel on the last allowed RUN cycle wins over the limit
        c = cyc;
        pulse_start();
        n = 0;
        while (cyc < c + MAXCYC && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("limit_cycle", cyc, c + MAXCYC);
        send_sentinel();
        wait_done(200);
`else
        c = 0;
`endif

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_result_checker.md
# dm_result_checker

Synthesizable end-of-test checker for the single-cycle CPU `top`. It snoops the data-memory write port and detects the sim-end sentinel write. It then scans a parametrised DM result window against a golden ROM, one word per cycle. It reports pass/fail, the error count, the first failing address and an optional cycle-limit timeout. It sits beside `i_DM` in FPGA and emulation builds, replacing the behavioural compare loop.

## Interface
- `ADDR_W`, 16: DM word-address width.
- `DATA_W`, 32: DM word width; byte strobes are `DATA_W/8`.
- `TEST_START`, 16'h2000: first DM word address of the result window.
- `TEST_LEN`, 64: number of words compared (at least 1).
- `SIM_END_ADDR`, 16'h3fff: sentinel word address.
- `SIM_END_CODE`, all ones (-1): sentinel value.
- `MAX_CYCLES`, 100000: RUN-cycle limit (used only with `CHECKER_TIMEOUT_EN`).
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: arm pulse; accepted in IDLE and DONE only.
- `dm_we` in DATA_W/8: snooped DM byte write enables.
- `dm_waddr` in ADDR_W: snooped DM write word address.
- `dm_wdata` in DATA_W: snooped DM write data.
- `dm_rd_en` out 1: scan read request.
- `dm_rd_addr` out ADDR_W: scan read address.
- `dm_rd_data` in DATA_W: DM read data, valid one cycle after `dm_rd_en`.
- `gold_rd_addr` out clog2(TEST_LEN): golden ROM index, issued together with `dm_rd_addr`.
- `gold_rd_data` in DATA_W: golden word; same one-cycle latency.
- `busy` out 1: high in RUN and SCAN.
- `done` out 1: high in DONE.
- `pass` out 1: valid while `done` is high.
- `timeout` out 1: RUN ended on the cycle limit.
- `err_cnt` out clog2(TEST_LEN+1): number of mismatching words.
- `first_err_valid` out 1: at least one mismatch occurred.
- `first_err_addr` out ADDR_W: DM address of the first mismatch.

## Operation
- The FSM has four states: IDLE, RUN, SCAN and DONE. Reset enters IDLE.
- All outputs reset to 0.
- Reset asserted mid-operation aborts immediately. All counters and flags clear and no partial result is retained.
- IDLE→RUN on `start`. This clears `err_cnt`, `first_err_*`, `timeout` and `pass`.
- RUN→SCAN when a sentinel write is seen. A sentinel write has `dm_we` all ones, `dm_waddr==SIM_END_ADDR` and `dm_wdata==SIM_END_CODE`.
  - Partial-strobe writes to the sentinel address are ignored.
- SCAN issues index i = 0..TEST_LEN-1, one per cycle:
  - `dm_rd_addr = TEST_START+i`.
  - `gold_rd_addr = i`.
  - `dm_rd_en = 1`.
- Compare stage: one cycle after each issue, compare `dm_rd_data` with `gold_rd_data` using a full-width `!=`.
  - On mismatch, `err_cnt` increments with saturating arithmetic.
  - The first mismatch latches `first_err_addr = TEST_START+i` and sets `first_err_valid`.
- After the compare for i = TEST_LEN-1, the FSM enters DONE.
  - `pass = (err_cnt==0) && !timeout`, counting the final compare.
- DONE holds all results until `start` (→RUN, results cleared) or reset.
- `start` during RUN or SCAN is ignored.
- Snooped writes outside RUN are ignored.
- `TEST_START+i` wraps modulo 2^ADDR_W. Windows that wrap are legal.

## Timing
- The sentinel write is sampled on the rising edge at the end of cycle N. SCAN is entered at N+1 and the first read issues at N+1.
- Scan latency: TEST_LEN issue cycles plus one compare cycle. `done` rises TEST_LEN+1 cycles after SCAN entry.
- `busy` and `done` are registered outputs and are never high at the same time.
- `dm_rd_en` is high for exactly TEST_LEN consecutive cycles per run.

## Configuration
- `CHECKER_TIMEOUT_EN` defined:
  - A RUN cycle counter counts from 0.
  - When it reaches MAX_CYCLES-1 without a sentinel, the FSM sets `timeout` and enters SCAN. The scan still runs for diagnostics.
  - `pass` is forced to 0 on timeout.
  - If the sentinel arrives in the same cycle as the limit, the sentinel wins and `timeout` stays 0.
- `CHECKER_TIMEOUT_EN` undefined:
  - No counter is built; `timeout` is tied to 0.
  - RUN lasts until the sentinel arrives or reset.

## Structure
- Shared package `checker_pkg` holds:
  - The FSM state enum.
  - Default `SIM_END_ADDR`, `SIM_END_CODE` and `TEST_START` constants, which the testbench also uses.
- Sub-module `checker_scan_ctrl` holds the issue index, one-stage compare pipeline, error counter and first-error latch. The top level holds the FSM, sentinel detect and timeout counter.

## Test plan
- Reset, then `start`. Write 0x1 to 16'h2000..16'h203f with golden equal, then write 32'hffffffff to 16'h3fff with `dm_we`=4'hf → `done` after 65 cycles, `pass`=1, `err_cnt`=0.
- Same run, but DM[16'h2005]=0xdead and DM[16'h2010]=0xbeef mismatch the golden ROM → `pass`=0, `err_cnt`=2, `first_err_addr`=16'h2005.
- Sentinel written with `dm_we`=4'h3 → FSM stays in RUN; a later full write → SCAN.
- With `CHECKER_TIMEOUT_EN`, MAX_CYCLES=100 and no sentinel → SCAN entered after 100 RUN cycles, then `timeout`=1 and `pass`=0. A sentinel on cycle 100 → `timeout`=0.
- Assert `rst` in the middle of SCAN (i=20) → all outputs 0 the same cycle. A subsequent `start` runs a clean pass.
- `start` pulsed during RUN → ignored. `start` in DONE → results cleared and FSM returns to RUN.
